// File: rtl/dm_pkg.sv
// ----------------------------------------------------------------
// dm_pkg: access-type encodings and response states for dm_pipe
// Revision 1.0
// ----------------------------------------------------------------
`default_nettype none

package dm_pkg;

  // Shared with the decode stage; the low two bits give the access size
  localparam logic [2:0] MT_W  = 3'b000;
  localparam logic [2:0] MT_B  = 3'b001;
  localparam logic [2:0] MT_H  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b101;
  localparam logic [2:0] MT_HU = 3'b110;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } resp_state_e;

  function automatic logic is_legal_mtype(input logic [2:0] mtype);
    case (mtype)
      MT_W, MT_B, MT_H, MT_BU, MT_HU: is_legal_mtype = 1'b1;
      default:                        is_legal_mtype = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lane_align.sv
// ----------------------------------------------------------------
// dm_lane_align: byte enables, store replication, load extract/extend
// Revision 1.0
// ----------------------------------------------------------------
`default_nettype none

module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  mtype,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    rdata     = 32'h0;
    case (mtype)
      MT_W: begin
        byte_en = 4'b1111;
        rdata   = word;
      end
      MT_B: begin
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{lane_b[7]}}, lane_b};
      end
      MT_BU: begin
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'h0, lane_b};
      end
      MT_H: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{lane_h[15]}}, lane_h};
      end
      MT_HU: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'h0, lane_h};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_pipe.sv
// ----------------------------------------------------------------
// dm_pipe: handshaked byte-addressed data RAM with one-entry response register
// Revision 1.0
// ----------------------------------------------------------------
`default_nettype none

module dm_pipe
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WORD_IDX_W  = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mtype,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              resp_is_store
);

  logic [31:0]           mem [DEPTH_WORDS];
  resp_state_e           state_q;
  resp_state_e           state_d;
  logic                  fire;
  logic                  addr_oor;
  logic                  misaligned;
  logic                  err;
  logic                  wr_en;
  logic [WORD_IDX_W-1:0] idx;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_rep;
  logic [31:0]           ld_data;
  logic [31:0]           rd_word;

  assign idx      = req_addr[WORD_IDX_W+1:2];
  assign addr_oor = |(req_addr >> (WORD_IDX_W + 2));

  always_comb begin
    misaligned = 1'b0;
    case (req_mtype)
      MT_W:        misaligned = (req_addr[1:0] != 2'b00);
      MT_H, MT_HU: misaligned = req_addr[0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign err = addr_oor || misaligned || !is_legal_mtype(req_mtype);

  // Holding req_ready low during reset keeps requests from writing the RAM
  assign resp_valid = (state_q == FULL);
  assign req_ready  = rst_n && (!resp_valid || resp_ready);
  assign fire       = req_valid && req_ready;
  assign wr_en      = fire && req_we && !err;
  assign rd_word    = mem[idx];

  dm_lane_align u_align (
    .mtype     (req_mtype),
    .offset    (req_addr[1:0]),
    .wdata     (req_wdata),
    .word      (rd_word),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // In FULL a fire implies resp_ready, so the register is simply reloaded
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (fire) state_d = FULL;
      FULL:    if (resp_ready && !fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata    <= 32'h0;
      resp_err      <= 1'b0;
      resp_is_store <= 1'b0;
    end else if (fire) begin
      resp_rdata    <= (err || req_we) ? 32'h0 : ld_data;
      resp_err      <= err;
      resp_is_store <= req_we;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_pipe.sv
// ----------------------------------------------------------------
// tb_dm_pipe: scoreboard bench for dm_pipe against a byte-array memory model
// Revision 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_dm_pipe;
  import dm_pkg::*;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mtype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_is_store;

  dm_pipe #(.ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_mtype     (req_mtype),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_is_store (resp_is_store)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        st;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_m [BYTES];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          head_seen = 0;
  logic [33:0] held;
  bit          rand_bp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, accesses as (size, signedness)
  function automatic exp_t model(input bit we, input logic [2:0] mt,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          sz = 1;
    bit          sgn = 0;
    bit          legal = 1;
    logic [31:0] v = 0;
    case (mt)
      MT_W:    begin sz = 4; sgn = 0; end
      MT_B:    begin sz = 1; sgn = 1; end
      MT_H:    begin sz = 2; sgn = 1; end
      MT_BU:   begin sz = 1; sgn = 0; end
      MT_HU:   begin sz = 2; sgn = 0; end
      default: legal = 0;
    endcase
    e.st    = we;
    e.rdata = 0;
    e.acc   = 0;
    e.err   = !legal || (addr >= 32'(BYTES)) || ((addr % sz) != 0);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[int'(addr) + i];
        if (sgn && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Monitor: pops one expectation per consumed response
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      head_seen = 0;
    end else if (resp_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: got rdata 0x%08h with no request outstanding", resp_rdata);
      end else begin
        if (!head_seen) begin
          chk("latency", 64'(cyc), 64'(sb[0].acc + 1));
          head_seen = 1;
          held = {resp_is_store, resp_err, resp_rdata};
        end else begin
          chk("stall_hold", 64'({resp_is_store, resp_err, resp_rdata}), 64'(held));
        end
        if (resp_ready) begin
          chk("rdata", 64'(resp_rdata), 64'(sb[0].rdata));
          chk("err", 64'(resp_err), 64'(sb[0].err));
          chk("is_store", 64'(resp_is_store), 64'(sb[0].st));
          void'(sb.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [2:0] mt, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_c = 0,
                       input logic [31:0] c_rd = 0, input bit c_err = 0);
    exp_t e;
    bit   done = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_mtype = mt;
    req_addr  = addr;
    req_wdata = wd;
    if (rand_bp) resp_ready = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (req_ready) begin
        e = model(we, mt, addr, wd);
        if (use_c) begin
          e.rdata = c_rd;
          e.err   = c_err;
        end
        e.acc = cyc;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (rand_bp) resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL accept_timeout: req_ready stayed 0 for 50 cycles, addr 0x%08h", addr);
    end
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  mt;
    int          r;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_mtype  = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_is_store", 64'(resp_is_store), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int w = 0; w < DEPTH; w++) issue(1, MT_W, 32'(w * 4), 32'h0);

    issue(1, MT_W, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
    issue(0, MT_W, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);

    issue(1, MT_W,  32'h20, 32'h80FF7F01, 1, 32'h0, 0);
    issue(0, MT_B,  32'h23, 32'h0, 1, 32'hFFFFFF80, 0);
    issue(0, MT_BU, 32'h23, 32'h0, 1, 32'h00000080, 0);
    issue(0, MT_H,  32'h22, 32'h0, 1, 32'hFFFF80FF, 0);
    issue(0, MT_HU, 32'h20, 32'h0, 1, 32'h00007F01, 0);
    issue(0, MT_B,  32'h20, 32'h0, 1, 32'h00000001, 0);

    issue(1, MT_W, 32'h30, 32'h11223344, 1, 32'h0, 0);
    issue(1, MT_B, 32'h31, 32'h123456AA, 1, 32'h0, 0);
    issue(1, MT_H, 32'h32, 32'hFFFFBEEF, 1, 32'h0, 0);
    issue(0, MT_W, 32'h30, 32'h0, 1, 32'hBEEFAA44, 0);

    issue(1, MT_W,   32'h40, 32'h55AA1234, 1, 32'h0, 0);
    issue(0, MT_W,   32'h41, 32'h0, 1, 32'h0, 1);
    issue(0, MT_H,   32'h43, 32'h0, 1, 32'h0, 1);
    issue(1, MT_W,   32'(BYTES), 32'hCAFEF00D, 1, 32'h0, 1);
    issue(1, 3'b111, 32'h40, 32'hCAFEF00D, 1, 32'h0, 1);
    issue(1, MT_W,   32'h42, 32'hCAFEF00D, 1, 32'h0, 1);
    issue(0, MT_W,   32'h40, 32'h0, 1, 32'h55AA1234, 0);
    drain();

    issue(0, MT_W, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    resp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", 64'(resp_rdata), 64'hDEADBEEF);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    issue(0, MT_W, 32'h20, 32'h0, 1, 32'h80FF7F01, 0);
    issue(0, MT_W, 32'h30, 32'h0, 1, 32'hBEEFAA44, 0);
    drain();

    issue(0, MT_W, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    resp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_rdata", 64'(resp_rdata), 64'd0);
    chk("async_rst_err", 64'(resp_err), 64'd0);
    sb.delete();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_mtype = MT_W;
    req_addr  = 32'h10;
    req_wdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    rst_n      = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    issue(0, MT_W, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    issue(0, MT_W, 32'h20, 32'h0, 1, 32'h80FF7F01, 0);
    drain();

    rand_bp = 1;
    repeat (400) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'($urandom_range(0, BYTES + 7));
      else             a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) mt = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0:       mt = MT_W;
          1:       mt = MT_B;
          2:       mt = MT_H;
          3:       mt = MT_BU;
          default: mt = MT_HU;
        endcase
      end
      issue(1'($urandom_range(0, 1)), mt, a, $urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
